// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed, checksummed byte stream,
// writes it into instruction memory as big-endian words and holds the CPU in reset until done.
module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              start_up,
    input  logic              load_go,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    // state  | meaning
    // S_IDLE | waiting for load_go after reset
    // S_HDR  | collecting the 2-byte big-endian word count
    // S_LOAD | collecting payload bytes, writing a word every 4 bytes
    // S_CHK  | comparing the trailing check byte against the running XOR
    // S_DONE | load good, CPU released
    // S_ERR  | load aborted (oversize or bad checksum)
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;

    localparam logic [31:0]     MAX32     = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        nhi_q, nhi_d;
    logic [15:0]       n_q, n_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              fire;
    logic [31:0]       hdr_n;
    logic [31:0]       words_nxt32;

    assign byte_ready  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
    assign fire        = byte_valid && byte_ready;
    assign hdr_n       = {16'd0, nhi_q, byte_data};
    assign words_nxt32 = 32'(words_q) + 32'd1;

    always_ff @(posedge clk or posedge start_up) begin
        if (start_up) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            nhi_q   <= 8'd0;
            n_q     <= 16'd0;
            word_q  <= 24'd0;
            csum_q  <= 8'd0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nhi_q   <= nhi_d;
            n_q     <= n_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nhi_d   = nhi_q;
        n_d     = n_q;
        word_d  = word_q;
        csum_d  = csum_q;
        words_d = words_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_go) begin
                    state_d = S_HDR;
                    cnt_d   = 2'd0;
                    csum_d  = 8'd0;
                    words_d = '0;
                end
            end
            S_HDR: begin
                if (fire) begin
                    if (cnt_q == 2'd0) begin
                        nhi_d = byte_data;
                        cnt_d = 2'd1;
                    end else begin
                        cnt_d = 2'd0;
                        n_d   = hdr_n[15:0];
                        if (hdr_n > MAX32)       state_d = S_ERR;
                        else if (hdr_n == 32'd0) state_d = S_CHK;
                        else                     state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (fire) begin
                    csum_d = csum_q ^ byte_data;
                    if (cnt_q == 2'd3) begin
                        // Only a fully assembled word is ever written.
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = {word_q, byte_data};
                        cnt_d   = 2'd0;
                        if (words_q != MAX_WORDS) words_d = words_q + ONE_WORD;
                        if (words_nxt32 == {16'd0, n_q}) state_d = S_CHK;
                    end else begin
                        word_d = {word_q[15:0], byte_data};
                        cnt_d  = cnt_q + 2'd1;
                    end
                end
            end
            S_CHK: begin
                if (fire) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign cpu_hold     = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, hand-written corner sequences and
// randomized loads checked against a stream-level reference model.
module tb_program_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          start_up;
    logic          load_go;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    program_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .start_up(start_up), .load_go(load_go), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] got[$];
    logic [63:0] exp_wr[$];

    // Every cycle with a write strobe is recorded, so a stuck or doubled pulse shows up.
    always @(negedge clk) begin
        if (imem_we) got.push_back({32'(imem_addr), imem_wdata});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_go();
        load_go = 1'b1;
        @(posedge clk); #1;
        load_go = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    // Reference model: decodes the stream purely from the framing and checksum rules.
    task automatic model(input logic [7:0] s[$], output bit e_done, output bit e_err,
                         output int e_words, output int consumed);
        int n;
        logic [7:0] cs;
        logic [31:0] w;
        exp_wr.delete();
        n = int'(s[0]) * 256 + int'(s[1]);
        e_done = 1'b0; e_err = 1'b0; e_words = 0; cs = 8'd0;
        if (n > (1 << AW)) begin
            e_err = 1'b1;
            consumed = 2;
        end else begin
            for (int k = 0; k < n; k++) begin
                w = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
                cs = cs ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
                exp_wr.push_back({32'(k), w});
            end
            e_words  = n;
            consumed = 2 + 4 * n + 1;
            if (s[2+4*n] == cs) e_done = 1'b1;
            else                e_err  = 1'b1;
        end
    endtask

    // gap >= 0: fixed idle cycles before each byte; gap < 0: random 0..2.
    task automatic feed(input logic [7:0] s[$], input int consumed, input int gap);
        for (int i = 0; i < consumed; i++)
            send_byte(s[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    endtask

    task automatic check_end(input string tag, input bit e_done, input bit e_err, input int e_words);
        check({tag, "_done"},     done,         e_done);
        check({tag, "_error"},    error,        e_err);
        check({tag, "_cpu_hold"}, cpu_hold,     !e_done);
        check({tag, "_words"},    words_loaded, e_words);
        check({tag, "_ready"},    byte_ready,   1'b0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_nwrites"}, got.size(), exp_wr.size());
        for (int i = 0; i < got.size() && i < exp_wr.size(); i++)
            check({tag, "_write"}, got[i], exp_wr[i]);
    endtask

    typedef struct packed {
        logic [127:0] bytes;
        logic [4:0]   len;
        logic [3:0]   gap;
        logic         e_done;
        logic         e_err;
        logic [3:0]   e_words;
        logic [1:0]   e_nw;
        logic [31:0]  e_d0;
        logic [31:0]  e_d1;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] s[$];

    initial begin
        bit    m_done, m_err;
        int    m_words, m_cons, n;
        logic [7:0] cs;
        logic [31:0] w;

        // XOR of 12 34 56 78 9A BC DE F0 is 00, so 00 is the good check byte.
        vecs[0] = '{128'h00021234_56789ABC_DEF00000_00000000, 5'd11, 4'd0, 1'b1, 1'b0, 4'd2, 2'd2, 32'h12345678, 32'h9ABCDEF0};
        vecs[1] = '{128'h00021234_56789ABC_DEF08900_00000000, 5'd11, 4'd0, 1'b0, 1'b1, 4'd2, 2'd2, 32'h12345678, 32'h9ABCDEF0};
        vecs[2] = '{128'h00000000_00000000_00000000_00000000, 5'd3,  4'd0, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0, 32'h0};
        vecs[3] = '{128'h04010000_00000000_00000000_00000000, 5'd2,  4'd0, 1'b0, 1'b1, 4'd0, 2'd0, 32'h0, 32'h0};
        vecs[4] = '{128'h00021234_56789ABC_DEF00000_00000000, 5'd11, 4'd3, 1'b1, 1'b0, 4'd2, 2'd2, 32'h12345678, 32'h9ABCDEF0};

        start_up = 1'b1; load_go = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
        #12;
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_ready",    byte_ready, 1'b0);
        check("rst_we",       imem_we, 1'b0);
        check("rst_addr",     imem_addr, 0);
        check("rst_wdata",    imem_wdata, 0);
        check("rst_flags",    {done, error}, 2'b00);
        check("rst_words",    words_loaded, 0);
        @(posedge clk); #1;
        start_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", byte_ready, 1'b0);

        // Directed vector table
        for (int v = 0; v < 5; v++) begin
            s.delete();
            for (int i = 0; i < int'(vecs[v].len); i++) s.push_back(vecs[v].bytes[127-8*i -: 8]);
            exp_wr.delete();
            if (vecs[v].e_nw > 0) exp_wr.push_back({32'd0, vecs[v].e_d0});
            if (vecs[v].e_nw > 1) exp_wr.push_back({32'd1, vecs[v].e_d1});
            pulse_go();
            check("go_ready", byte_ready, 1'b1);
            got.delete();
            feed(s, int'(vecs[v].len), int'(vecs[v].gap));
            check_end($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err, int'(vecs[v].e_words));
        end

        // Reset while the first word's write strobe is visible
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        pulse_go();
        got.delete();
        feed(s, 6, 0);
        check("pre_rst_we", imem_we, 1'b1);
        start_up = 1'b1;
        #1;
        check("midrst_we",       imem_we, 1'b0);
        check("midrst_words",    words_loaded, 0);
        check("midrst_cpu_hold", cpu_hold, 1'b1);
        check("midrst_ready",    byte_ready, 1'b0);
        check("midrst_addr",     {32'(imem_addr), imem_wdata}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        start_up = 1'b0;
        @(posedge clk); #1;
        check("postrst_nwrites",  got.size(), 0);
        check("postrst_cpu_hold", cpu_hold, 1'b1);

        // Complete load after reset, with load_go pulsed mid-LOAD (must be ignored)
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        model(s, m_done, m_err, m_words, m_cons);
        pulse_go();
        got.delete();
        feed(s, 4, 0);
        pulse_go();
        check("ignored_go_ready", byte_ready, 1'b1);
        for (int i = 4; i < 10; i++) send_byte(s[i], 0);
        check("pre_done_cpu_hold", cpu_hold, 1'b1);
        send_byte(s[10], 0);
        check_end("ignore_go", m_done, m_err, m_words);

        // Restart from DONE
        pulse_go();
        check("restart_cpu_hold", cpu_hold, 1'b1);
        check("restart_done",     done, 1'b0);
        check("restart_ready",    byte_ready, 1'b1);
        check("restart_words",    words_loaded, 0);
        s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h08};
        model(s, m_done, m_err, m_words, m_cons);
        got.delete();
        feed(s, m_cons, 1);
        check_end("restart", m_done, m_err, m_words);

        // Randomized loads against the reference model
        for (int it = 0; it < 30; it++) begin
            s.delete();
            if ($urandom_range(0, 7) == 0) begin
                n = (1 << AW) + 1 + int'($urandom_range(0, 2000));
                s.push_back(8'(n >> 8));
                s.push_back(8'(n));
            end else begin
                n = int'($urandom_range(0, 8));
                s.push_back(8'(n >> 8));
                s.push_back(8'(n));
                cs = 8'd0;
                for (int k = 0; k < 4 * n; k++) begin
                    s.push_back(8'($urandom));
                    cs = cs ^ s[s.size()-1];
                end
                s.push_back(($urandom_range(0, 3) == 0) ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
            end
            model(s, m_done, m_err, m_words, m_cons);
            pulse_go();
            got.delete();
            feed(s, m_cons, -1);
            check_end($sformatf("rand%0d", it), m_done, m_err, m_words);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
